uart_cmd_master: RTL and testbench
==================================

# uart_cmd_master

Host-side command initiator for the system's UART command frame protocol. It takes a single parallel command request (register-file write or read, or an ALU operation with or without new operands), serializes it into the frame byte stream through a byte-wide UART transmitter handshake, and collects and assembles the response bytes returned through a UART receiver. It is used in the loopback test harness and in any companion host device, talking to the system's UART pins through its own UART transmitter and receiver.

## Interface

- DATA_WIDTH, 8, byte width of the UART data path
- TIMEOUT_W, 16, width of the timeout counter and TIMEOUT input

- CLK  in  1  single clock; all logic on rising edge
- RST  in  1  reset, asynchronous, active-low
- CMD_VLD  in  1  command request valid
- CMD_RDY  out  1  high only in IDLE; a command is accepted on a CLK edge where CMD_VLD & CMD_RDY
- CMD_TYPE  in  2  00 RF write, 01 RF read, 10 ALU with operands, 11 ALU without operands
- CMD_ADDR  in  4  register-file address
- CMD_DATA  in  DATA_WIDTH  register-file write data
- CMD_OPA, CMD_OPB  in  DATA_WIDTH  ALU operands
- CMD_FUN  in  4  ALU function code
- TX_DATA  out  DATA_WIDTH  byte to the transmitter
- TX_VLD  out  1  one-cycle pulse qualifying TX_DATA
- TX_BUSY  in  1  transmitter busy, already synchronized to CLK
- RX_DATA  in  DATA_WIDTH  byte from the receiver
- RX_VLD  in  1  one-cycle pulse qualifying RX_DATA, already synchronized to CLK
- TIMEOUT  in  TIMEOUT_W  wait limit in CLK cycles; 0 disables the timeout
- RSP_DATA  out  2*DATA_WIDTH  assembled response
- RSP_VLD  out  1  one-cycle pulse: command completed successfully
- RSP_ERR  out  1  one-cycle pulse: command aborted on timeout

## Operation

- Frames, transmitted first byte to last byte:
  - RF write: AA, {4'h0,ADDR}, DATA. No response bytes.
  - RF read: BB, {4'h0,ADDR}. 1 response byte.
  - ALU with operands: CC, OPA, OPB, {4'h0,FUN}. 2 response bytes, LSB first.
  - ALU without operands: DD, {4'h0,FUN}. 2 response bytes, LSB first.
- On acceptance, all CMD_* inputs are captured. Later input changes have no effect.
- States:
  - IDLE: CMD_RDY=1. On accept, go to SEND with byte index 0.
  - SEND: pulse TX_VLD for 1 cycle with the byte at the current index, then go to WAIT_HI.
  - WAIT_HI: wait for TX_BUSY=1, then go to WAIT_LO.
  - WAIT_LO: wait for TX_BUSY=0. Then:
    - if more bytes remain, increment the index and go to SEND;
    - else, if response bytes are expected, go to RSP;
    - else, complete the command.
  - RSP: capture each RX_VLD byte, placing byte 0 in RSP_DATA[7:0] and byte 1 in RSP_DATA[15:8]. After the last expected byte, complete the command.
- Completion:
  - On the edge that finishes the command, the state returns to IDLE.
  - RSP_VLD=1 for one cycle.
  - RSP_DATA holds the result: 0 for RF write, {8'h00,byte} for RF read, and the 16-bit result for ALU commands.
- Timeout:
  - A counter clears on entry to WAIT_HI and to RSP, and on every RX_VLD accepted in RSP. It increments on every other cycle spent in WAIT_HI or RSP.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT, the state goes to IDLE, RSP_ERR pulses for one cycle, and RSP_DATA keeps its previous value.
  - WAIT_LO has no timeout.
- RX_VLD outside RSP is ignored: no capture, no error. Extra response bytes after completion are also ignored.
- Bytes are counted with a 2-bit index. TX bytes per command: 3/2/4/2. RSP bytes per command: 0/1/2/2.

## Timing

- Reset values: state IDLE, CMD_RDY=1, TX_DATA=0, TX_VLD=0, RSP_DATA=0, RSP_VLD=0, RSP_ERR=0, index and counter 0.
- If RST is asserted mid-command, all of the above apply immediately. No partial frame is resumed and no RSP_VLD or RSP_ERR is issued.
- Command accepted at edge k: TX_VLD=1 with byte 0 during cycle k+1.
- After TX_BUSY falls, detected at edge j, the next TX_VLD is high during cycle j+1.
- The last RX_VLD is sampled at edge t: RSP_VLD=1 and CMD_RDY=1 during cycle t+1. A new command may be accepted at edge t+1.
- RF write: RSP_VLD is high in the cycle after the final TX_BUSY fall is detected.
- TX_VLD is never high for two consecutive cycles. At most one byte is outstanding at any time.
- RSP_VLD and RSP_ERR are never high together.

## Test plan

- RF write, ADDR=3, DATA=0x5A, transmitter model with a 10-cycle busy → TX bytes AA,03,5A. RSP_VLD pulses once with RSP_DATA=0x0000. CMD_RDY is low throughout the command.
- RF read, ADDR=2, responder returns 0x81 → TX bytes BB,02. RSP_DATA=0x0081. RSP_VLD fires exactly 1 cycle after that RX_VLD.
- ALU with operands, OPA=0x0C, OPB=0x0A, FUN=0, responder returns 16, 00 → TX bytes CC,0C,0A,00. RSP_DATA=0x0016. A new command issued back-to-back with CMD_VLD held high is accepted in the RSP_VLD cycle.
- ALU without operands, FUN=2, TIMEOUT=50, only 1 response byte returned → RSP_ERR pulses 50 cycles after that byte. RSP_VLD stays 0 and the state returns to IDLE. Repeat with TIMEOUT=0 → the block waits indefinitely.
- Stray RX_VLD during SEND and WAIT_LO → ignored; RSP_DATA is unchanged. TX_BUSY held low for 20 cycles with TIMEOUT=20 → RSP_ERR.
- RST asserted during WAIT_LO of byte 2 → outputs immediately at reset values. After release, a fresh RF read completes normally.

Source files
------------

// File: rtl/uart_cmd_master_if.sv
// Command, UART byte-stream and response signals of the UART command master.
// The master modport is the command master's own view; slave is the environment side.
interface uart_cmd_master_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT_W  = 16
);
  logic                    cmd_vld;
  logic                    cmd_rdy;
  logic [1:0]              cmd_type;
  logic [3:0]              cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_data;
  logic [DATA_WIDTH-1:0]   cmd_opa;
  logic [DATA_WIDTH-1:0]   cmd_opb;
  logic [3:0]              cmd_fun;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    tx_vld;
  logic                    tx_busy;
  logic [DATA_WIDTH-1:0]   rx_data;
  logic                    rx_vld;
  logic [TIMEOUT_W-1:0]    timeout;
  logic [2*DATA_WIDTH-1:0] rsp_data;
  logic                    rsp_vld;
  logic                    rsp_err;

  modport master (
    input  cmd_vld, cmd_type, cmd_addr, cmd_data, cmd_opa, cmd_opb, cmd_fun,
    input  tx_busy, rx_data, rx_vld, timeout,
    output cmd_rdy, tx_data, tx_vld, rsp_data, rsp_vld, rsp_err
  );

  modport slave (
    output cmd_vld, cmd_type, cmd_addr, cmd_data, cmd_opa, cmd_opb, cmd_fun,
    output tx_busy, rx_data, rx_vld, timeout,
    input  cmd_rdy, tx_data, tx_vld, rsp_data, rsp_vld, rsp_err
  );
endinterface

// File: rtl/uart_cmd_master.sv
// Host-side UART command initiator: serializes one command into a frame,
// one byte in flight at a time, then assembles the response with a timeout.
module uart_cmd_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_cmd_master_if.master ifc
);
  localparam int unsigned RSP_W = 2 * DATA_WIDTH;
  localparam logic [1:0] CMD_WR      = 2'b00;
  localparam logic [1:0] CMD_RD      = 2'b01;
  localparam logic [1:0] CMD_ALU     = 2'b10;
  localparam logic [1:0] CMD_ALU_NOP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO, S_RSP
  } state_e;

  state_e                state_q;
  logic [1:0]            idx_q;
  logic [1:0]            type_q;
  logic [3:0]            addr_q;
  logic [3:0]            fun_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] opa_q;
  logic [DATA_WIDTH-1:0] opb_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic [TIMEOUT_W-1:0]  cnt_q;
  logic                  cmd_rdy_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_vld_q;
  logic [RSP_W-1:0]      rsp_data_q;
  logic                  rsp_vld_q;
  logic                  rsp_err_q;

  // Frame byte at position idx for a given command.
  function automatic logic [DATA_WIDTH-1:0] frame_byte(
    input logic [1:0]            typ,
    input logic [1:0]            idx,
    input logic [3:0]            addr,
    input logic [DATA_WIDTH-1:0] data,
    input logic [DATA_WIDTH-1:0] opa,
    input logic [DATA_WIDTH-1:0] opb,
    input logic [3:0]            fun
  );
    logic [DATA_WIDTH-1:0] b;
    b = '0;
    case (typ)
      CMD_WR: begin
        case (idx)
          2'd0:    b = DATA_WIDTH'(8'hAA);
          2'd1:    b = DATA_WIDTH'(addr);
          default: b = data;
        endcase
      end
      CMD_RD:      b = (idx == 2'd0) ? DATA_WIDTH'(8'hBB) : DATA_WIDTH'(addr);
      CMD_ALU: begin
        case (idx)
          2'd0:    b = DATA_WIDTH'(8'hCC);
          2'd1:    b = opa;
          2'd2:    b = opb;
          default: b = DATA_WIDTH'(fun);
        endcase
      end
      default:     b = (idx == 2'd0) ? DATA_WIDTH'(8'hDD) : DATA_WIDTH'(fun);
    endcase
    return b;
  endfunction

  logic [1:0]            last_tx_c;
  logic [1:0]            last_rx_c;
  logic [1:0]            idx_inc_c;
  logic [TIMEOUT_W-1:0]  cnt_inc_c;
  logic                  timeout_hit_c;
  logic [DATA_WIDTH-1:0] next_byte_c;

  // Last TX byte index and last RX byte index of the captured command.
  always_comb begin
    last_tx_c = 2'd1;
    last_rx_c = 2'd1;
    case (type_q)
      CMD_WR:  last_tx_c = 2'd2;
      CMD_RD:  last_rx_c = 2'd0;
      CMD_ALU: last_tx_c = 2'd3;
      default: ;
    endcase
  end

  assign idx_inc_c     = idx_q + 2'd1;
  assign cnt_inc_c     = cnt_q + TIMEOUT_W'(1);
  assign timeout_hit_c = (ifc.timeout != '0) && (cnt_inc_c == ifc.timeout);
  assign next_byte_c   = frame_byte(type_q, idx_inc_c, addr_q, data_q, opa_q, opb_q, fun_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      type_q     <= '0;
      addr_q     <= '0;
      fun_q      <= '0;
      data_q     <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      cmd_rdy_q  <= 1'b1;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      tx_vld_q  <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ifc.cmd_vld) begin
            type_q    <= ifc.cmd_type;
            addr_q    <= ifc.cmd_addr;
            data_q    <= ifc.cmd_data;
            opa_q     <= ifc.cmd_opa;
            opb_q     <= ifc.cmd_opb;
            fun_q     <= ifc.cmd_fun;
            idx_q     <= '0;
            tx_data_q <= frame_byte(ifc.cmd_type, 2'd0, ifc.cmd_addr, ifc.cmd_data,
                                    ifc.cmd_opa, ifc.cmd_opb, ifc.cmd_fun);
            tx_vld_q  <= 1'b1;
            cmd_rdy_q <= 1'b0;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (ifc.tx_busy) begin
            state_q <= S_WAIT_LO;
          end else if (timeout_hit_c) begin
            rsp_err_q <= 1'b1;
            cmd_rdy_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_inc_c;
          end
        end
        S_WAIT_LO: begin
          if (!ifc.tx_busy) begin
            if (idx_q != last_tx_c) begin
              idx_q     <= idx_inc_c;
              tx_data_q <= next_byte_c;
              tx_vld_q  <= 1'b1;
              state_q   <= S_SEND;
            end else if (type_q != CMD_WR) begin
              idx_q   <= '0;
              cnt_q   <= '0;
              state_q <= S_RSP;
            end else begin
              rsp_data_q <= '0;
              rsp_vld_q  <= 1'b1;
              cmd_rdy_q  <= 1'b1;
              state_q    <= S_IDLE;
            end
          end
        end
        S_RSP: begin
          if (ifc.rx_vld) begin
            cnt_q <= '0;
            if (idx_q == last_rx_c) begin
              rsp_data_q <= (type_q == CMD_RD) ? RSP_W'(ifc.rx_data) : {ifc.rx_data, lo_q};
              rsp_vld_q  <= 1'b1;
              cmd_rdy_q  <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              lo_q  <= ifc.rx_data;
              idx_q <= idx_inc_c;
            end
          end else if (timeout_hit_c) begin
            rsp_err_q <= 1'b1;
            cmd_rdy_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_inc_c;
          end
        end
        default: begin
          cmd_rdy_q <= 1'b1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign ifc.cmd_rdy  = cmd_rdy_q;
  assign ifc.tx_data  = tx_data_q;
  assign ifc.tx_vld   = tx_vld_q;
  assign ifc.rsp_data = rsp_data_q;
  assign ifc.rsp_vld  = rsp_vld_q;
  assign ifc.rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Self-checking bench for uart_cmd_master: directed protocol scenarios plus
// randomized commands against a frame/response model built from the protocol rules.
module tb_uart_cmd_master;
  typedef logic [7:0] bq_t[$];

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  uart_cmd_master_if #(.DATA_WIDTH(8), .TIMEOUT_W(16)) bus ();
  uart_cmd_master #(.DATA_WIDTH(8), .TIMEOUT_W(16)) dut (.clk(clk), .rst_n(rst_n), .ifc(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model state
  logic [7:0] tx_q[$];
  int         tx_done;
  bit         tx_mute;
  int         hi_delay;
  int         busy_len;

  // Current / next command and model of RSP_DATA
  logic [1:0]  cur_t, nxt_t;
  logic [3:0]  cur_a, cur_f, nxt_a, nxt_f;
  logic [7:0]  cur_d, cur_oa, cur_ob, cur_r0, cur_r1;
  logic [7:0]  nxt_d, nxt_oa, nxt_ob;
  logic [15:0] exp_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t exp_frame(input logic [1:0] t, input logic [3:0] a,
                                    input logic [7:0] d, input logic [7:0] oa,
                                    input logic [7:0] ob, input logic [3:0] f);
    bq_t q;
    case (t)
      2'd0: begin q.push_back(8'hAA); q.push_back({4'h0, a}); q.push_back(d); end
      2'd1: begin q.push_back(8'hBB); q.push_back({4'h0, a}); end
      2'd2: begin q.push_back(8'hCC); q.push_back(oa); q.push_back(ob); q.push_back({4'h0, f}); end
      default: begin q.push_back(8'hDD); q.push_back({4'h0, f}); end
    endcase
    return q;
  endfunction

  function automatic int exp_nrsp(input logic [1:0] t);
    return (t == 2'd0) ? 0 : (t == 2'd1) ? 1 : 2;
  endfunction

  function automatic logic [15:0] exp_rsp(input logic [1:0] t, input logic [7:0] r0, input logic [7:0] r1);
    return (t == 2'd0) ? 16'h0000 : (t == 2'd1) ? {8'h00, r0} : {r1, r0};
  endfunction

  // Transmitter: records each byte, then optionally goes busy for busy_len cycles
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.tx_vld === 1'b1) begin
        tx_q.push_back(bus.tx_data);
        if (!tx_mute) begin
          repeat (hi_delay) @(posedge clk);
          #1 bus.tx_busy = 1'b1;
          repeat (busy_len) @(posedge clk);
          #1 bus.tx_busy = 1'b0;
          tx_done++;
        end
      end
    end
  end

  // Protocol invariants
  initial begin
    logic prev_tx;
    prev_tx = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_vld === 1'b1) check("tx_vld_back_to_back", 32'(prev_tx), 0);
      if ((bus.rsp_vld | bus.rsp_err) === 1'b1) check("vld_err_together", 32'(bus.rsp_vld & bus.rsp_err), 0);
      prev_tx = bus.tx_vld;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  task automatic issue_cmd(input string tag, input bit stray);
    bq_t ef;
    int  k;
    ef = exp_frame(cur_t, cur_a, cur_d, cur_oa, cur_ob, cur_f);
    k  = 0;
    while (bus.cmd_rdy !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    check({tag, " rdy_before"}, 32'(bus.cmd_rdy), 1);
    tx_q.delete();
    tx_done = 0;
    bus.cmd_vld = 1'b1; bus.cmd_type = cur_t; bus.cmd_addr = cur_a; bus.cmd_data = cur_d;
    bus.cmd_opa = cur_oa; bus.cmd_opb = cur_ob; bus.cmd_fun = cur_f;
    @(negedge clk);
    bus.cmd_vld = 1'b0; bus.cmd_type = 2'($urandom); bus.cmd_addr = 4'($urandom);
    bus.cmd_data = 8'($urandom); bus.cmd_opa = 8'($urandom); bus.cmd_opb = 8'($urandom);
    bus.cmd_fun = 4'($urandom);
    check({tag, " first_tx_vld"}, 32'(bus.tx_vld), 1);
    check({tag, " first_byte"}, 32'(bus.tx_data), 32'(ef[0]));
    check({tag, " rdy_low"}, 32'(bus.cmd_rdy), 0);
    if (stray) begin
      bus.rx_vld = 1'b1; bus.rx_data = 8'($urandom);
      @(negedge clk);
      bus.rx_vld = 1'b0;
    end
  endtask

  task automatic wait_tx(input string tag, input bit stray);
    bq_t ef;
    int  k;
    bit  rdy_hi, early;
    ef = exp_frame(cur_t, cur_a, cur_d, cur_oa, cur_ob, cur_f);
    k = 0; rdy_hi = 0; early = 0;
    while (tx_done < ef.size() && k < 3000) begin
      bus.rx_vld  = stray && (bus.tx_busy === 1'b1);
      bus.rx_data = 8'($urandom);
      @(negedge clk);
      k++;
      if (bus.cmd_rdy !== 1'b0) rdy_hi = 1;
      if ((bus.rsp_vld | bus.rsp_err) !== 1'b0) early = 1;
    end
    bus.rx_vld = 1'b0;
    check({tag, " tx_done"}, 32'(tx_done), 32'(ef.size()));
    check({tag, " rdy_low_during"}, 32'(rdy_hi), 0);
    check({tag, " no_early_rsp"}, 32'(early), 0);
    check({tag, " rsp_data_held"}, 32'(bus.rsp_data), 32'(exp_hold));
    check({tag, " tx_count"}, 32'(tx_q.size()), 32'(ef.size()));
    for (int i = 0; i < ef.size() && i < tx_q.size(); i++)
      check($sformatf("%s tx_byte%0d", tag, i), 32'(tx_q[i]), 32'(ef[i]));
  endtask

  task automatic rsp_phase(input string tag, input int gap, input bit b2b);
    int          nr;
    logic [15:0] er;
    bq_t         ef;
    nr = exp_nrsp(cur_t);
    er = exp_rsp(cur_t, cur_r0, cur_r1);
    @(negedge clk);
    for (int i = 0; i < nr; i++) begin
      repeat (gap) @(negedge clk);
      if (i != 0) @(negedge clk);
      bus.rx_vld  = 1'b1;
      bus.rx_data = (i == 0) ? cur_r0 : cur_r1;
      if (b2b && i == nr - 1) begin
        bus.cmd_vld = 1'b1; bus.cmd_type = nxt_t; bus.cmd_addr = nxt_a; bus.cmd_data = nxt_d;
        bus.cmd_opa = nxt_oa; bus.cmd_opb = nxt_ob; bus.cmd_fun = nxt_f;
      end
      @(negedge clk);
      bus.rx_vld  = 1'b0;
      bus.rx_data = 8'($urandom);
      if (i < nr - 1) check({tag, " no_vld_mid"}, 32'(bus.rsp_vld), 0);
    end
    check({tag, " rsp_vld"}, 32'(bus.rsp_vld), 1);
    check({tag, " rsp_err"}, 32'(bus.rsp_err), 0);
    check({tag, " rsp_data"}, 32'(bus.rsp_data), 32'(er));
    check({tag, " rdy_at_done"}, 32'(bus.cmd_rdy), 1);
    exp_hold = er;
    if (b2b) begin
      tx_q.delete();
      tx_done = 0;
      cur_t = nxt_t; cur_a = nxt_a; cur_d = nxt_d; cur_oa = nxt_oa; cur_ob = nxt_ob; cur_f = nxt_f;
      ef = exp_frame(cur_t, cur_a, cur_d, cur_oa, cur_ob, cur_f);
      @(negedge clk);
      bus.cmd_vld = 1'b0;
      check({tag, " b2b_tx_vld"}, 32'(bus.tx_vld), 1);
      check({tag, " b2b_byte0"}, 32'(bus.tx_data), 32'(ef[0]));
      check({tag, " b2b_rdy_low"}, 32'(bus.cmd_rdy), 0);
    end else begin
      @(negedge clk);
      check({tag, " single_pulse"}, 32'(bus.rsp_vld), 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cmd_rdy"}, 32'(bus.cmd_rdy), 1);
    check({tag, " tx_data"}, 32'(bus.tx_data), 0);
    check({tag, " tx_vld"}, 32'(bus.tx_vld), 0);
    check({tag, " rsp_data"}, 32'(bus.rsp_data), 0);
    check({tag, " rsp_vld"}, 32'(bus.rsp_vld), 0);
    check({tag, " rsp_err"}, 32'(bus.rsp_err), 0);
  endtask

  initial begin
    int c;
    bit seen_vld, seen_err, seen_tx;
    rst_n = 1'b0;
    bus.cmd_vld = 0; bus.cmd_type = 0; bus.cmd_addr = 0; bus.cmd_data = 0;
    bus.cmd_opa = 0; bus.cmd_opb = 0; bus.cmd_fun = 0;
    bus.rx_vld = 0; bus.rx_data = 0; bus.timeout = 0;
    tx_mute = 0; hi_delay = 1; busy_len = 10; tx_done = 0; exp_hold = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // RF write, ADDR=3 DATA=5A, 10-cycle busy
    cur_t = 2'd0; cur_a = 4'h3; cur_d = 8'h5A; cur_oa = 0; cur_ob = 0; cur_f = 0;
    issue_cmd("rfwr", 0); wait_tx("rfwr", 0); rsp_phase("rfwr", 0, 0);

    // RF read, ADDR=2, response 81
    cur_t = 2'd1; cur_a = 4'h2; cur_r0 = 8'h81;
    issue_cmd("rfrd", 0); wait_tx("rfrd", 0); rsp_phase("rfrd", 0, 0);

    // ALU with operands, then back-to-back RF write
    cur_t = 2'd2; cur_oa = 8'h0C; cur_ob = 8'h0A; cur_f = 4'h0; cur_r0 = 8'h16; cur_r1 = 8'h00;
    nxt_t = 2'd0; nxt_a = 4'h5; nxt_d = 8'h3C; nxt_oa = 0; nxt_ob = 0; nxt_f = 0;
    issue_cmd("alu", 0); wait_tx("alu", 0); rsp_phase("alu", 2, 1);
    wait_tx("b2b_wr", 0); rsp_phase("b2b_wr", 0, 0);

    // ALU without operands, TIMEOUT=50, only one response byte
    bus.timeout = 16'd50; busy_len = 4;
    cur_t = 2'd3; cur_f = 4'h2; cur_r0 = 8'h9E; cur_r1 = 8'h42;
    issue_cmd("to50", 0); wait_tx("to50", 0);
    @(negedge clk);
    bus.rx_vld = 1'b1; bus.rx_data = cur_r0;
    @(negedge clk);
    bus.rx_vld = 1'b0;
    c = 0; seen_vld = 0;
    while (c < 120) begin
      @(negedge clk); c++;
      if (bus.rsp_vld === 1'b1) seen_vld = 1;
      if (bus.rsp_err === 1'b1) break;
    end
    check("to50 err_latency", 32'(c), 50);
    check("to50 no_vld", 32'(seen_vld), 0);
    check("to50 rdy", 32'(bus.cmd_rdy), 1);
    check("to50 data_kept", 32'(bus.rsp_data), 32'(exp_hold));
    @(negedge clk);
    check("to50 err_pulse", 32'(bus.rsp_err), 0);

    // Same with TIMEOUT=0: waits indefinitely, then completes on the second byte
    bus.timeout = 16'd0;
    issue_cmd("to0", 0); wait_tx("to0", 0);
    @(negedge clk);
    bus.rx_vld = 1'b1; bus.rx_data = cur_r0;
    @(negedge clk);
    bus.rx_vld = 1'b0;
    seen_vld = 0; seen_err = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.rsp_vld === 1'b1) seen_vld = 1;
      if (bus.rsp_err === 1'b1) seen_err = 1;
    end
    check("to0 no_err", 32'(seen_err), 0);
    check("to0 no_vld", 32'(seen_vld), 0);
    check("to0 still_busy", 32'(bus.cmd_rdy), 0);
    bus.rx_vld = 1'b1; bus.rx_data = cur_r1;
    @(negedge clk);
    bus.rx_vld = 1'b0;
    check("to0 late_vld", 32'(bus.rsp_vld), 1);
    check("to0 late_data", 32'(bus.rsp_data), 32'({cur_r1, cur_r0}));
    exp_hold = {cur_r1, cur_r0};

    // Stray RX_VLD during SEND and WAIT_LO
    busy_len = 6;
    cur_t = 2'd2; cur_oa = 8'h33; cur_ob = 8'h44; cur_f = 4'h7; cur_r0 = 8'h5C; cur_r1 = 8'hE1;
    issue_cmd("stray", 1); wait_tx("stray", 1); rsp_phase("stray", 1, 0);

    // Transmitter never goes busy, TIMEOUT=20
    bus.timeout = 16'd20; tx_mute = 1;
    cur_t = 2'd0; cur_a = 4'h9; cur_d = 8'h11;
    issue_cmd("wait_hi_to", 0);
    c = 0;
    while (c < 100) begin
      @(negedge clk); c++;
      if (bus.rsp_err === 1'b1) break;
    end
    check("wait_hi_to latency", 32'(c), 21);
    check("wait_hi_to data_kept", 32'(bus.rsp_data), 32'(exp_hold));
    check("wait_hi_to rdy", 32'(bus.cmd_rdy), 1);
    tx_mute = 0;
    @(negedge clk);

    // Reset during WAIT_LO of byte 2
    bus.timeout = 16'd0; busy_len = 8; hi_delay = 1;
    cur_t = 2'd2; cur_oa = 8'h01; cur_ob = 8'h02; cur_f = 4'h3;
    issue_cmd("rst_mid", 0);
    c = 0;
    while (!(tx_q.size() == 3 && bus.tx_busy === 1'b1) && c < 500) begin @(negedge clk); c++; end
    check("rst_mid reached_byte2", 32'(tx_q.size()), 3);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    exp_hold = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen_tx = 0; seen_vld = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tx_vld === 1'b1) seen_tx = 1;
      if ((bus.rsp_vld | bus.rsp_err) === 1'b1) seen_vld = 1;
    end
    check("rst_mid no_resume", 32'(seen_tx), 0);
    check("rst_mid no_rsp", 32'(seen_vld), 0);
    cur_t = 2'd1; cur_a = 4'h7; cur_r0 = 8'hC3;
    issue_cmd("post_rst", 0); wait_tx("post_rst", 0); rsp_phase("post_rst", 0, 0);

    // Randomized commands
    for (int n = 0; n < 12; n++) begin
      string tag;
      int    gap;
      bit    st;
      tag = $sformatf("rnd%0d", n);
      cur_t = 2'($urandom); cur_a = 4'($urandom); cur_d = 8'($urandom);
      cur_oa = 8'($urandom); cur_ob = 8'($urandom); cur_f = 4'($urandom);
      cur_r0 = 8'($urandom); cur_r1 = 8'($urandom);
      hi_delay = $urandom_range(0, 3);
      busy_len = $urandom_range(2, 6);
      bus.timeout = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(40, 200));
      gap = $urandom_range(0, 4);
      st  = 1'($urandom);
      issue_cmd(tag, st); wait_tx(tag, st); rsp_phase(tag, gap, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
